transition_marker_gen: RTL

//  Transmit side of the FE/FF marker protocol on a 32-bit word bus. Drives bursts of FE marker words (all ones, LSB 0)

---
 rtl/transition_marker_gen_if.sv | 27 ++
 rtl/transition_marker_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/transition_marker_gen_if.sv
// Start handshake and burst configuration between a burst requester and the
// FE/FF marker generator.
`timescale 1ns/1ps

interface transition_marker_gen_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] cfg_count;
    logic [GAP_W-1:0] cfg_gap;

    modport master (
        output start_valid,
        output cfg_count,
        output cfg_gap,
        input  start_ready
    );

    modport slave (
        input  start_valid,
        input  cfg_count,
        input  cfg_gap,
        output start_ready
    );
endinterface

// File: rtl/transition_marker_gen.sv
// Transmit side of the FE/FF marker protocol: bursts of FE marker words
// separated by programmable idle gaps, with an FF clear word on abort.
// Optional feature macro: TMG_SPACING_GUARD_EN (effective gap = max(cfg_gap,3)).
`timescale 1ns/1ps

module transition_marker_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      CNT_W     = 8,
    parameter int unsigned      GAP_W     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    transition_marker_gen_if.slave start_if,
    input  logic                   abort,
    output logic [WIDTH-1:0]       out,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [CNT_W-1:0]       markers_sent
);

    localparam logic [WIDTH-1:0] FE_WORD = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] FF_WORD = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MARK  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (IDLE_WORD == FE_WORD || IDLE_WORD == FF_WORD) begin : g_idle_word_chk
        $error("IDLE_WORD must differ from the FE marker and FF clear words");
    end

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] cnt_cfg;
    logic [GAP_W-1:0] gap_cfg;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             last_mark;

    function automatic logic [GAP_W-1:0] eff_gap(input logic [GAP_W-1:0] g);
`ifdef TMG_SPACING_GUARD_EN
        return (g < GAP_W'(3)) ? GAP_W'(3) : g;
`else
        return g;
`endif
    endfunction

    assign accept    = (state == S_IDLE) && start_if.start_ready && start_if.start_valid;
    assign last_mark = ((markers_sent + CNT_ONE) == cnt_cfg);

    // Next-state selection; abort takes priority over marker completion and gap expiry
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = (start_if.cfg_count == '0) ? S_DONE : S_MARK;
                end
            end
            S_MARK: begin
                if (abort)               state_nx = S_CLEAR;
                else if (last_mark)      state_nx = S_DONE;
                else if (gap_cfg == '0)  state_nx = S_MARK;
                else                     state_nx = S_GAP;
            end
            S_GAP: begin
                if (abort)               state_nx = S_CLEAR;
                else if (gap_cnt == '0)  state_nx = S_MARK;
            end
            S_CLEAR: state_nx = S_IDLE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; every output is registered as a function of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= S_IDLE;
            out                  <= IDLE_WORD;
            start_if.start_ready <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            aborted              <= 1'b0;
        end else begin
            state                <= state_nx;
            start_if.start_ready <= (state_nx == S_IDLE);
            busy                 <= (state_nx == S_MARK) || (state_nx == S_GAP) || (state_nx == S_CLEAR);
            done                 <= (state_nx == S_DONE);
            aborted              <= (state_nx == S_CLEAR);
            case (state_nx)
                S_MARK:  out <= FE_WORD;
                S_CLEAR: out <= FF_WORD;
                default: out <= IDLE_WORD;
            endcase
        end
    end

    // Burst configuration latch, marker counter and gap countdown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_cfg      <= '0;
            gap_cfg      <= '0;
            gap_cnt      <= '0;
            markers_sent <= '0;
        end else begin
            if (accept) begin
                cnt_cfg      <= start_if.cfg_count;
                gap_cfg      <= eff_gap(start_if.cfg_gap);
                markers_sent <= '0;
            end else if (state == S_MARK) begin
                markers_sent <= markers_sent + CNT_ONE;
            end
            // Countdown runs gap_cfg-1 .. 0 so GAP lasts exactly gap_cfg cycles
            if (state != S_GAP && state_nx == S_GAP) begin
                gap_cnt <= gap_cfg - GAP_ONE;
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
        end
    end

endmodule
